// File: rtl/minn_pkg.sv
// Shared types and helpers for the Minn timing-metric windowed-sum path.
package minn_pkg;

  localparam int DEFAULT_IN_WIDTH = 16;
  localparam int DEFAULT_WINDOW   = 16;

  typedef logic signed [DEFAULT_IN_WIDTH-1:0] sample_t;

  // FILL_FULL is reached on the WINDOW-th accept and left only on rst/flush.
  typedef enum logic {
    FILL_FILLING = 1'b0,
    FILL_FULL    = 1'b1
  } fill_state_e;

  // Width that holds the sum of `window` signed samples of `in_width` bits.
  function automatic int sum_width(input int in_width, input int window);
    return in_width + $clog2(window);
  endfunction

endpackage

// File: rtl/minn_window_ram.sv
// Circular sample buffer: combinational read of the slot about to be overwritten,
// write and pointer advance on we. Storage is not reset so it can map to RAM.
module minn_window_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W-1:0] wr_ptr
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      wr_ptr <= '0;
    end else if (we) begin
      wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Read-before-write: rdata is the sample that entered DEPTH writes ago.
  assign rdata = mem[wr_ptr];

endmodule

// File: rtl/minn_window_sum.sv
// Sliding-window accumulator: running sum of the last WINDOW accepted samples,
// registered with one cycle of latency.
module minn_window_sum
  import minn_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
  parameter int WINDOW   = DEFAULT_WINDOW,
  localparam int SUM_WIDTH = sum_width(IN_WIDTH, WINDOW)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  output logic signed [SUM_WIDTH-1:0] out_sum,
  output logic                        window_full
);

  // Handshake: in_valid has no backpressure, every strobed sample is taken
  // unless rst/flush is high that cycle; out_valid is a one-cycle pulse the
  // cycle after an accept, only once the window holds WINDOW samples.

  if (WINDOW < 1) begin : g_window_check
    $error("minn_window_sum: WINDOW must be >= 1");
  end

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  fill_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            fill_cnt_q, fill_cnt_d;
  logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q;
  logic                        accept;
  logic [IN_WIDTH-1:0]         oldest_raw;
  logic signed [IN_WIDTH-1:0]  oldest;
  logic [PTR_W-1:0]            wr_ptr;

  assign accept = in_valid && !rst && !flush;

  minn_window_ram #(
    .WIDTH(IN_WIDTH),
    .DEPTH(WINDOW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .restart(flush),
    .we     (accept),
    .wdata  (in_data),
    .rdata  (oldest_raw),
    .wr_ptr (wr_ptr)
  );

  // Until the window has filled, the slot under wr_ptr is stale; subtract 0.
  assign oldest = (state_q == FILL_FULL) ? $signed(oldest_raw) : '0;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    acc_d      = acc_q;
    if (accept) begin
      acc_d = acc_q + SUM_WIDTH'(in_data) - SUM_WIDTH'(oldest);
      if (fill_cnt_q != CNT_W'(WINDOW)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
      if (state_q == FILL_FILLING && fill_cnt_q == CNT_W'(WINDOW - 1)) begin
        state_d = FILL_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= FILL_FILLING;
      fill_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= accept && (state_d == FILL_FULL);
    end
  end

  assign out_sum     = acc_q;
  assign out_valid   = out_valid_q;
  assign window_full = (state_q == FILL_FULL);

endmodule

// File: tb/tb_minn_window_sum.sv
// Bench for minn_window_sum: three instances (WINDOW 4, 16, 1), directed and
// random stimulus, queue-based reference model and scoreboard.
module tb_minn_window_sum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]         in_valid_v = '0;
  logic [2:0]         flush_v    = '0;
  logic signed [15:0] in_data_v [3];

  logic               ov0, ov1, ov2;
  logic               wf0, wf1, wf2;
  logic signed [17:0] os0;
  logic signed [19:0] os1;
  logic signed [15:0] os2;

  minn_window_sum #(.IN_WIDTH(16), .WINDOW(4)) u_w4 (
    .clk(clk), .rst(rst), .flush(flush_v[0]), .in_valid(in_valid_v[0]),
    .in_data(in_data_v[0]), .out_valid(ov0), .out_sum(os0), .window_full(wf0));

  minn_window_sum #(.IN_WIDTH(16), .WINDOW(16)) u_w16 (
    .clk(clk), .rst(rst), .flush(flush_v[1]), .in_valid(in_valid_v[1]),
    .in_data(in_data_v[1]), .out_valid(ov1), .out_sum(os1), .window_full(wf1));

  minn_window_sum #(.IN_WIDTH(16), .WINDOW(1)) u_w1 (
    .clk(clk), .rst(rst), .flush(flush_v[2]), .in_valid(in_valid_v[2]),
    .in_data(in_data_v[2]), .out_valid(ov2), .out_sum(os2), .window_full(wf2));

  int   got_sum [3];
  logic got_valid [3];
  logic got_full [3];
  assign got_sum[0] = int'(os0);
  assign got_sum[1] = int'(os1);
  assign got_sum[2] = int'(os2);
  assign got_valid[0] = ov0;
  assign got_valid[1] = ov1;
  assign got_valid[2] = ov2;
  assign got_full[0] = wf0;
  assign got_full[1] = wf1;
  assign got_full[2] = wf2;

  // Reference model: the window is literally the list of the last WINDOW samples.
  int          win_len [3] = '{4, 16, 1};
  int          win_q [3][$];
  logic [32:0] exp_q [3][$];
  int          last_sum [3] = '{0, 0, 0};
  bit          exp_full [3] = '{0, 0, 0};
  bit          acc_last [3] = '{0, 0, 0};
  int          obs_sum [3] = '{0, 0, 0};
  bit          mon_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input int k, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", name, k, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (acc_last[k]) begin
          acc_last[k] = 1'b0;
          if (exp_q[k].size() == 0) begin
            chk("missing_expectation", k, 1, 0);
          end else begin
            logic [32:0] e;
            e = exp_q[k].pop_front();
            chk("out_sum", k, got_sum[k], int'(e[31:0]));
            chk("out_valid", k, got_valid[k], e[32]);
            chk("window_full", k, got_full[k], e[32]);
            last_sum[k] = int'(e[31:0]);
            exp_full[k] = e[32];
          end
        end else begin
          chk("idle_out_valid", k, got_valid[k], 0);
          chk("idle_out_sum_hold", k, got_sum[k], last_sum[k]);
          chk("idle_window_full", k, got_full[k], exp_full[k]);
        end
        obs_sum[k] = got_sum[k];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model(input int k);
    win_q[k].delete();
    exp_q[k].delete();
    last_sum[k] = 0;
    exp_full[k] = 1'b0;
    acc_last[k] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    for (int k = 0; k < 3; k++) clear_model(k);
    #1 rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic step(input int k, input bit v, input bit f, input int d);
    in_valid_v[k] = v;
    flush_v[k]    = f;
    in_data_v[k]  = 16'(d);
    @(posedge clk);
    if (f) begin
      clear_model(k);
    end else if (v) begin
      int s;
      win_q[k].push_back(d);
      if (win_q[k].size() > win_len[k]) void'(win_q[k].pop_front());
      s = 0;
      for (int i = 0; i < win_q[k].size(); i++) s += win_q[k][i];
      exp_q[k].push_back({win_q[k].size() == win_len[k], 32'(s)});
      acc_last[k] = 1'b1;
    end
    #1;
    in_valid_v[k] = 1'b0;
    flush_v[k]    = 1'b0;
    in_data_v[k]  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_const(input string name, input int k, input int exp);
    @(negedge clk);
    #1;
    chk(name, k, obs_sum[k], exp);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) in_data_v[k] = '0;
    do_reset(2);
    idle(1);

    // Back-to-back 1..6 on WINDOW=4.
    for (int i = 1; i <= 6; i++) step(0, 1'b1, 1'b0, i);
    chk_const("w4_b2b_final", 0, 18);

    // Same samples with idle gaps after a flush.
    step(0, 1'b0, 1'b1, 0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 1'b1, 1'b0, i);
      idle($urandom_range(0, 3));
    end
    chk_const("w4_gaps_final", 0, 18);

    // Extremes on WINDOW=16.
    for (int i = 0; i < 20; i++) step(1, 1'b1, 1'b0, -32768);
    chk_const("w16_min", 1, -524288);
    for (int i = 0; i < 16; i++) step(1, 1'b1, 1'b0, 32767);
    chk_const("w16_max", 1, 524272);

    // Flush mid-stream, then flush coincident with a sample.
    for (int i = 1; i <= 6; i++) step(0, 1'b1, 1'b0, i);
    step(0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1);
    chk_const("w4_after_flush", 0, 4);
    step(0, 1'b1, 1'b1, 9);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1);
    chk_const("w4_flush_with_valid", 0, 4);

    // Reset mid-stream.
    for (int i = 0; i < 6; i++) step(0, 1'b1, 1'b0, 100);
    do_reset(1);
    chk_const("w4_after_reset", 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 7);
    chk_const("w4_after_reset_fill", 0, 28);

    // WINDOW=1.
    step(2, 1'b1, 1'b0, 5);
    chk_const("w1_first", 2, 5);
    step(2, 1'b1, 1'b0, -3);
    step(2, 1'b1, 1'b0, 8);
    chk_const("w1_last", 2, 8);

    // Random traffic on every instance.
    for (int n = 0; n < 600; n++) begin
      int k;
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        step(k, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
             int'($urandom_range(0, 65535)) - 32768);
      end
    end

    idle(3);
    for (int k = 0; k < 3; k++) chk("scoreboard_drained", k, exp_q[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/minn_window_sum.md
Name: minn_window_sum

Overview:
- Sliding-window accumulator for the Minn timing-metric path.
- Each accepted sample adds the new value to a running sum and subtracts the sample that entered WINDOW accepted samples earlier.
- The delay line only delays the stream; this block consumes the delayed (oldest) sample to form the windowed sum.
- Feeds the Minn metric/peak stage; one instance per correlation or energy term.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- WINDOW, 16, window length in accepted samples; must be >= 1 (elaboration $error otherwise).
- SUM_WIDTH is a derived localparam, not overridable: IN_WIDTH + $clog2(WINDOW).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous window restart; same effect as rst on this block's state.
- in_valid  input  1  sample strobe; no backpressure, every strobed sample is accepted.
- in_data  input  IN_WIDTH  signed sample.
- out_valid  output  1  out_sum is a full-window result for the sample accepted last cycle.
- out_sum  output  SUM_WIDTH  signed windowed sum, registered.
- window_full  output  1  level; at least WINDOW samples accepted since the last rst/flush.

Behaviour:
- Reset (rst=1): out_sum=0, out_valid=0, window_full=0, accumulator=0, write pointer=0, fill count=0.
  - Buffer contents are not cleared and need not be.
- Fill count n: accepted samples since the last rst/flush, saturating at WINDOW.
- Oldest sample: buffer[wr_ptr], read before write in the same cycle.
  - Forced to 0 while n < WINDOW (before this sample), so stale contents are never subtracted.
- Accept cycle (in_valid=1, rst=0, flush=0):
  - acc <= acc + in_data - oldest;
  - buffer[wr_ptr] <= in_data;
  - wr_ptr wraps WINDOW-1 -> 0;
  - n increments until saturated.
- Latency: one cycle. out_sum equals the new acc on the cycle after acceptance.
- out_valid: high on the cycle after an accepted sample iff n >= WINDOW including that sample; low on every other cycle.
- out_sum: updated on every accept, including during fill (partial sum of the min(n, WINDOW) samples so far). Holds its value in idle cycles.
- window_full: registered. Rises with the first out_valid; stays high until rst/flush.
- Arithmetic:
  - in_data and oldest are sign-extended to SUM_WIDTH.
  - No saturation; SUM_WIDTH guarantees no overflow for any input sequence.
- Priority: rst > flush > in_valid.
  - flush together with in_valid: the sample is discarded.
  - Next accepted sample is the first of a new window.
- Reset or flush mid-window: the next window starts clean; no pre-reset sample contributes.
- No internal state machine beyond the fill counter (FILLING -> FULL on the WINDOW-th accept; FULL -> FILLING only on rst/flush).

Decomposition:
- Package minn_pkg:
  - sum-width helper function (in_width, window) -> in_width + $clog2(window);
  - sample typedef at default width.
- Sub-module minn_window_ram:
  - circular buffer with WIDTH and DEPTH parameters, combinational read at wr_ptr, write on in_valid, pointer wrap;
  - no reset of storage, so it maps to distributed/block RAM.
- Accumulator, fill counter and output registers stay in minn_window_sum.

Test Plan:
1. WINDOW=4: accept 1,2,3,4,5,6 back-to-back -> out_sum 1,3,6,10,14,18; out_valid 0,0,0,1,1,1; window_full rises with the value 10.
2. Same samples with 0–3 idle cycles between accepts -> identical out_sum sequence; out_valid only on the cycle after each accept; out_sum holds during gaps.
3. WINDOW=16, IN_WIDTH=16: 20x -32768 -> out_sum -524288 from the 16th accept, no wrap; then 16x 32767 -> 524272.
4. WINDOW=4: after 6 samples assert flush, then accept 1,1,1,1 -> out_sum 1,2,3,4; out_valid only on 4. Repeat with flush coincident with in_valid (data 9) -> the 9 is absent from every sum.
5. WINDOW=4: fill with 100s, assert rst for one cycle mid-stream, then accept 7,7,7,7 -> all outputs 0 after reset; out_sum 7,14,21,28; out_valid only on 28.
6. WINDOW=1: accept 5,-3,8 -> out_sum 5,-3,8, each with out_valid=1.
